bin2bcd_seq_n: RTL

Parametrised sequential binary-to-BCD converter using shift-add-3 (double dabble). It is the successor of the fixed three-digit, unsigned converter that sits between integer producers (float-to-int, counters) and the hex/BCD multiplexed display.
- Generalised in input width and digit count.
- Adds an optional two's-complement input mode with sign output, an overflow flag, and a one-entry input holding register so a start pulse during a conversion is queued rather than lost.

---
 rtl/bcd_pkg.sv | 25 ++
 rtl/bin2bcd_seq_n_if.sv | 27 ++
 rtl/bcd_digit_adj.sv | 8 +
 rtl/bin2bcd_seq_n.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter and the display mux:
// digit codes, the converter FSM state type and a power-of-ten helper.
package bcd_pkg;

  // Digit codes understood by the multiplexed display driver.
  localparam logic [4:0] BLANK = 5'b10010;
  localparam logic [4:0] DASH  = 5'b10000;

  // Converter sequencing states.
  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    FINISH
  } state_t;

  // 10^n, used to size the overflow threshold at elaboration time.
  function automatic int unsigned pow10(input int unsigned n);
    int unsigned p;
    p = 1;
    for (int unsigned i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_n_if.sv
// Request/result bundle of bin2bcd_seq_n. The master issues conversion
// requests; the slave (the converter) returns the BCD result and status.
interface bin2bcd_seq_n_if #(
  parameter int W      = 10,
  parameter int DIGITS = 3
);
  logic                  start;
  logic                  signed_mode;
  logic [W-1:0]          bin;
  logic                  ready;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  neg;
  logic                  of;
  logic [DIGITS-1:0]     blank;

  modport master (
    output start, signed_mode, bin,
    input  ready, busy, done, bcd, neg, of, blank
  );

  modport slave (
    input  start, signed_mode, bin,
    output ready, busy, done, bcd, neg, of, blank
  );
endinterface

// File: rtl/bcd_digit_adj.sv
// Single BCD digit correction cell for double dabble: a digit of 5 or more
// gets 3 added so that the following left shift carries into the next digit.
module bcd_digit_adj (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/bin2bcd_seq_n.sv
// Sequential W-bit binary to DIGITS-digit BCD converter (shift-add-3) with
// optional two's-complement input, overflow flag and a one-entry request
// queue. Optional macro LEADING_ZERO_BLANK_EN enables the leading-zero blank
// mask; without it the blank output is tied to zero.
module bin2bcd_seq_n
  import bcd_pkg::*;
#(
  parameter int W      = 10,
  parameter int DIGITS = 3
) (
  input  logic              clk,
  input  logic              reset,
  bin2bcd_seq_n_if.slave    bus
);

  localparam int          BW    = 4 * DIGITS;
  localparam int          CW    = $clog2(W + 1);
  localparam logic [31:0] LIMIT = pow10(DIGITS);

  state_t          state_q, state_d;
  logic            q_valid, q_sm, in_sm;
  logic [W-1:0]    q_bin, in_bin, mag_sh, mag_calc;
  logic [BW-1:0]   bcd_sh, bcd_adj, bcd_next, bcd_q;
  logic [CW-1:0]   cnt;
  logic            neg_pend, of_pend, neg_q, of_q;
  logic            last_shift;

  // Magnitude of the captured request; the most negative value wraps to 2^(W-1).
  assign mag_calc   = (in_sm && in_bin[W-1]) ? -in_bin : in_bin;
  assign bcd_next   = {bcd_adj[BW-2:0], mag_sh[W-1]};
  assign last_shift = (state_q == SHIFT) && (cnt == CW'(1));

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d (bcd_sh[4*g +: 4]),
      .q (bcd_adj[4*g +: 4])
    );
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state is always assigned with <= so every register sees
    // the pre-edge values of the others, independent of statement order.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: the default assignment up front keeps this block free of latches
    // even on paths that do not mention state_d.
    state_d = state_q;
    case (state_q)
      IDLE:    if (q_valid || bus.start) state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT:   if (cnt == CW'(1)) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = (state_q == FINISH);
  assign bus.ready = (state_q == IDLE) && !q_valid;
  assign bus.bcd   = bcd_q;
  assign bus.neg   = neg_q;
  assign bus.of    = of_q;

  // Request capture/queue, shift datapath and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: every datapath register is reset as well so a mid-conversion
      // reset leaves no stale request or partial result behind.
      q_valid  <= 1'b0;
      q_bin    <= '0;
      q_sm     <= 1'b0;
      in_bin   <= '0;
      in_sm    <= 1'b0;
      bcd_sh   <= '0;
      mag_sh   <= '0;
      cnt      <= '0;
      neg_pend <= 1'b0;
      of_pend  <= 1'b0;
      bcd_q    <= '0;
      neg_q    <= 1'b0;
      of_q     <= 1'b0;
    end else begin
      if (state_q == IDLE) begin
        if (q_valid) begin
          in_bin  <= q_bin;
          in_sm   <= q_sm;
          q_valid <= bus.start;
          if (bus.start) begin
            q_bin <= bus.bin;
            q_sm  <= bus.signed_mode;
          end
        end else if (bus.start) begin
          in_bin <= bus.bin;
          in_sm  <= bus.signed_mode;
        end
      end else if (bus.start) begin
        q_valid <= 1'b1;
        q_bin   <= bus.bin;
        q_sm    <= bus.signed_mode;
      end

      case (state_q)
        LOAD: begin
          mag_sh   <= mag_calc;
          bcd_sh   <= '0;
          cnt      <= CW'(W);
          neg_pend <= in_sm && in_bin[W-1];
          of_pend  <= 32'(mag_calc) >= LIMIT;
        end
        SHIFT: begin
          bcd_sh <= bcd_next;
          mag_sh <= {mag_sh[W-2:0], 1'b0};
          cnt    <= cnt - CW'(1);
          if (last_shift) begin
            bcd_q <= bcd_next;
            neg_q <= neg_pend;
            of_q  <= of_pend;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank_calc, blank_q;
  logic              lead;

  // Blank leading zero digits from the top down; digit 0 always shows.
  always_comb begin
    blank_calc = '0;
    lead       = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (!lead && (bcd_next[4*i +: 4] == 4'd0)) blank_calc[i] = 1'b1;
      else                                       lead          = 1'b1;
    end
  end

  // Blank mask is updated together with the BCD result.
  always_ff @(posedge clk) begin
    if (reset)           blank_q <= '0;
    else if (last_shift) blank_q <= blank_calc;
  end

  assign bus.blank = blank_q;
`else
  assign bus.blank = '0;
`endif

endmodule
